// File: rtl/NCL_signals.sv
// Shared NCL types: dual-rail bit encoding, wavefront constants and the transmitter FSM states.
package NCL_signals;

  typedef struct packed {
    logic rail1;
    logic rail0;
  } dual_rail_logic;

  localparam dual_rail_logic DR_NULL  = '{rail1: 1'b0, rail0: 1'b0};
  localparam dual_rail_logic DR_DATA0 = '{rail1: 1'b0, rail0: 1'b1};
  localparam dual_rail_logic DR_DATA1 = '{rail1: 1'b1, rail0: 1'b0};

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StNull
  } ncl_tx_state_t;

  function automatic dual_rail_logic dr_encode(input logic b);
    return b ? DR_DATA1 : DR_DATA0;
  endfunction

endpackage

// File: rtl/ncl_sync2.sv
// Two-flop synchronizer for a single asynchronous control bit, reset to 0.
module ncl_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sr2ncl_tx.sv
// Single-rail to NCL dual-rail transmitter with 4-phase DATA/NULL handshake on ki.
// Optional acknowledge watchdog enabled by defining SR2NCL_TX_TIMEOUT_EN.
module sr2ncl_tx
  import NCL_signals::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic           [WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output dual_rail_logic [WIDTH-1:0]  ncl_out,
  input  logic                        ki,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  logic                        ki_s;
  ncl_tx_state_t               state_q, state_d;
  dual_rail_logic [WIDTH-1:0]  ncl_q, ncl_d;

  ncl_sync2 u_ki_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ki),
    .q_o   (ki_s)
  );

  assign in_ready = (state_q == StIdle) && ki_s;
  assign busy     = (state_q != StIdle);
  assign ncl_out  = ncl_q;

  always_comb begin
    state_d = state_q;
    ncl_d   = ncl_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          state_d = StData;
          for (int i = 0; i < int'(WIDTH); i++) begin
            ncl_d[i] = dr_encode(in_data[i]);
          end
        end
      end
      StData: begin
        if (!ki_s) begin
          state_d = StNull;
          for (int i = 0; i < int'(WIDTH); i++) begin
            ncl_d[i] = DR_NULL;
          end
        end
      end
      StNull: begin
        if (ki_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        for (int i = 0; i < int'(WIDTH); i++) begin
          ncl_d[i] = DR_NULL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ncl_q   <= '0;
    end else begin
      state_q <= state_d;
      ncl_q   <= ncl_d;
    end
  end

`ifdef SR2NCL_TX_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Count restarts on every state change and saturates so a long stall never re-arms.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != StIdle) begin
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
      if (cnt_d == TimeoutCnt) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCnt;
  assign timeout_err    = 1'b0;
`endif

endmodule
